// File: rtl/load_store_unit.sv
// load_store_unit: byte-addressed load/store requests -> word memory accesses with lane masks,
// replicated store data, extended load data and error flagging for illegal accesses.
module load_store_unit #(
  parameter int DW = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  localparam int ADDRW = $clog2(MEM_SIZE_IN_KB*1024/4)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             req_we_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_addr_i,
  input  logic [DW-1:0]    req_wdata_i,
  output logic             rsp_valid_o,
  output logic [DW-1:0]    rsp_rdata_o,
  output logic             rsp_err_o,
  output logic             dm_cs_o,
  output logic             dm_we_o,
  output logic [3:0]       dm_mask_o,
  output logic [ADDRW-1:0] dm_addr_o,
  output logic [DW-1:0]    dm_wdata_o,
  input  logic [DW-1:0]    dm_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nx;
  logic accept, legal_f3, misal, oor, legal, sign;
  logic [1:0] sz, r_off;
  logic [2:0] r_f3;
  logic r_we, r_err;
  logic [3:0] mask;
  logic [DW-1:0] wrep, sh, ld;
  assign sz = req_funct3_i[1:0];
  assign accept = req_valid_i && req_ready_o;
  assign legal_f3 = req_we_i ? (req_funct3_i inside {3'b000, 3'b001, 3'b010})
                             : (req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
  assign misal = (sz == 2'd1 && req_addr_i[0]) || (sz == 2'd2 && req_addr_i[1:0] != 2'd0);
  assign oor = |req_addr_i[31:ADDRW+2];
  assign legal = legal_f3 && !misal && !oor;
  assign mask = sz == 2'd0 ? 4'b0001 << req_addr_i[1:0] :
                sz == 2'd1 ? 4'b0011 << req_addr_i[1:0] : 4'b1111;
  assign wrep = sz == 2'd0 ? {4{req_wdata_i[7:0]}} :
                sz == 2'd1 ? {2{req_wdata_i[15:0]}} : req_wdata_i;
  assign sh = dm_rdata_i >> {r_off, 3'b000};
  assign sign = !r_f3[2];
  assign ld = r_f3[1] ? sh :
              r_f3[0] ? {{16{sign & sh[15]}}, sh[15:0]} : {{24{sign & sh[7]}}, sh[7:0]};
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = req_valid_i ? ACCESS : IDLE;
      ACCESS:  state_nx = RESP;
      default: state_nx = req_valid_i ? ACCESS : IDLE;
    endcase
  end
  always_comb begin
    req_ready_o = state != ACCESS;
    rsp_valid_o = state == RESP;
  end
  // Memory strobes are registered at accept so they are live only for the ACCESS cycle.
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      dm_cs_o     <= 1'b0;
      dm_we_o     <= 1'b0;
      dm_mask_o   <= '0;
      dm_addr_o   <= '0;
      dm_wdata_o  <= '0;
      r_off       <= '0;
      r_f3        <= '0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      dm_cs_o    <= accept && legal;
      dm_we_o    <= accept && legal && req_we_i;
      dm_mask_o  <= accept && legal ? mask : 4'b0000;
      dm_addr_o  <= accept && legal ? req_addr_i[ADDRW+1:2] : '0;
      dm_wdata_o <= accept && legal ? wrep : '0;
      if (accept) begin
        r_off <= req_addr_i[1:0];
        r_f3  <= req_funct3_i;
        r_we  <= req_we_i;
        r_err <= !legal;
      end
      if (state == ACCESS) begin
        rsp_rdata_o <= (r_err || r_we) ? '0 : ld;
        rsp_err_o   <= r_err;
      end
    end
endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store unit sitting directly upstream of the word-addressable data memory. It accepts one byte-addressed load or store request at a time from the execute/memory pipeline stage and converts it into a word address, byte-lane mask and lane-replicated write data. It extracts and sign/zero-extends load data from the returned word, and flags misaligned, out-of-range and illegal accesses instead of issuing them.

## Interface

Parameters:
- DW, 32, data width; only 32 is supported.
- MEM_SIZE_IN_KB, 1, data memory size; must match the memory instance.
- ADDRW, localparam = $clog2(MEM_SIZE_IN_KB*1024/4), word-address width.

Ports:
- clk_i  in  1  clock; all flops on rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RISC-V funct3 (size/sign).
- req_addr_i  in  32  byte address.
- req_wdata_i  in  32  store data (rs2), right-justified.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  request was rejected (misaligned, out of range, or illegal funct3).
- dm_cs_o  out  1  memory chip select.
- dm_we_o  out  1  memory write enable.
- dm_mask_o  out  4  byte-lane write mask.
- dm_addr_o  out  ADDRW  word address.
- dm_wdata_o  out  32  lane-replicated write data.
- dm_rdata_i  in  32  memory read word (combinational read of dm_addr_o).

## Operation

- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready_o=1. On req_valid_i, the request is registered and the state moves to ACCESS.
- ACCESS: if the registered request is legal, dm_cs_o=1, dm_we_o=req_we, and mask/addr/wdata are driven from registers. If illegal, all dm_* outputs are 0. At the end of the cycle, load data is extracted from dm_rdata_i into the response register, and the state moves to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle; req_ready_o=1. A new request accepted here goes to ACCESS; otherwise the state returns to IDLE.
- Loads, funct3 legal set: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores, funct3 legal set: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Misaligned: a halfword access with addr[0]=1, or a word access with addr[1:0]≠0.
- Out of range: addr[31:ADDRW+2] ≠ 0.
- dm_addr_o = addr[ADDRW+1:2].
- Store mask:
  - byte: 4'b0001 << addr[1:0]
  - half: 4'b0011 << addr[1:0]
  - word: 4'b1111
- Store data:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction:
  - Shift dm_rdata_i right by 8*addr[1:0], then take 8/16/32 bits.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Errors: rsp_err_o=1, rsp_rdata_o=0, and memory is never touched.

## Timing

- Reset values: state IDLE, req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, all dm_* outputs 0. Requests presented while rst_ni is low are discarded.
- Latency: request accepted at edge N; memory access during cycle N+1 (a store commits at edge N+2); rsp_valid_o high during cycle N+2.
- Throughput: one request per 2 cycles in back-to-back operation (accept in RESP).
- dm_* outputs are registered and glitch-free. They are nonzero only in ACCESS with a legal request.
- rsp_rdata_o and rsp_err_o hold their values until the next response; rsp_valid_o qualifies them.
- Reset asserted during ACCESS: dm_cs_o and dm_we_o drop asynchronously, so the store does not commit if reset precedes the edge. No response is produced for the aborted request.
- req_valid_i while req_ready_o=0 (ACCESS) is ignored. The requester must hold the request until it sees ready.

## Test plan

- SW 0xDEADBEEF to 0x10, then LW 0x10: ACCESS cycle shows mask 1111, addr 4; load response rdata=0xDEADBEEF, err=0, valid exactly 2 cycles after accept.
- With word 4 = 0x80FF7F01, issue LB/LBU/LH/LHU at 0x13, 0x13, 0x12, 0x12 -> 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF.
- SB 0xAB to 0x21 over word 0x11223344 -> mask 0010, wdata 0xABABABAB; a following LW of 0x20 returns 0x1122AB44.
- Errors, with no cs pulse and memory unchanged:
  - LH at 0x01 -> err=1, rdata=0.
  - SW at 0x06 -> err=1.
  - Out-of-range LW at 0x400 (1 KB) -> err=1.
  - funct3=011 load -> err=1.
- Back-to-back: valid held for 3 requests -> accepts at cycles 0, 2 and 4; rsp_valid at 2, 4 and 6.
- Assert rst_ni low mid-ACCESS of SW 0x55 to 0x0 -> all outputs at reset values immediately, word 0 unchanged, no rsp_valid.
